// File: rtl/router_sync_n.sv
// router_sync_n: destination latch, write steering, full mux and per-channel read-stall watchdogs
module router_sync_n #(
  parameter int NUM_CH = 3,
  parameter int TIMEOUT = 30,
  localparam int AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              detect_add,
  input  logic [AW-1:0]     datain,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] full,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err
);
  logic [AW-1:0]     dest_q, dest_d;
  logic              addr_err_q, addr_err_d;
  logic [CW-1:0]     cnt_q [NUM_CH];
  logic [CW-1:0]     cnt_d [NUM_CH];
  logic [NUM_CH-1:0] soft_reset_q, soft_reset_d;
  logic [NUM_CH-1:0] stall;
  logic              dest_ok;
  assign dest_ok    = int'(dest_q) < NUM_CH;
  assign vld_out    = ~empty;
  assign stall      = vld_out & ~read_enb;
  assign write_enb  = (write_enb_reg && dest_ok) ? NUM_CH'(1) << dest_q : '0;
  assign fifo_full  = dest_ok ? full[dest_q] : 1'b0;
  assign soft_reset = soft_reset_q;
  assign addr_err   = addr_err_q;
  // capture a new destination and its range check on the header strobe
  always_comb begin
    dest_d     = detect_add ? datain : dest_q;
    addr_err_d = detect_add ? (int'(datain) >= NUM_CH) : addr_err_q;
  end
  // count consecutive stalled cycles; wrap to zero with a one-cycle pulse on the last one
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]        = (stall[i] && cnt_q[i] != CW'(TIMEOUT - 1)) ? cnt_q[i] + 1'b1 : '0;
      soft_reset_d[i] = stall[i] && cnt_q[i] == CW'(TIMEOUT - 1);
    end
  end
  // state registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dest_q       <= '0;
      addr_err_q   <= 1'b0;
      soft_reset_q <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      dest_q       <= dest_d;
      addr_err_q   <= addr_err_d;
      soft_reset_q <= soft_reset_d;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end
endmodule

// File: tb/tb_router_sync_n.sv
// tb_router_sync_n: randomized scoreboard bench for two router_sync_n configurations
module tb_router_sync_n;
  typedef struct packed {
    logic [3:0] we;
    logic [3:0] vld;
    logic [3:0] sr;
    logic       ff;
    logic       ae;
  } obs_t;
  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       detect_add = 1'b0;
  logic       write_enb_reg = 1'b0;
  logic [1:0] datain = '0;
  logic [3:0] rd = '0;
  logic [3:0] emp = '1;
  logic [3:0] ful = '0;
  logic [2:0] we0, vld0, sr0;
  logic       ff0, ae0;
  logic [3:0] we1, vld1, sr1;
  logic       ff1, ae1;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   nrst = 0;
  int   npulse = 0;

  int   nch[2] = '{3, 4};
  int   tmo[2] = '{30, 5};
  int   dest[2];
  bit   err[2];
  int   run[2][4];
  bit   pulse[2][4];

  always #5 clk = ~clk;

  router_sync_n #(.NUM_CH(3), .TIMEOUT(30)) u0 (
    .clk(clk), .reset(reset), .detect_add(detect_add), .datain(datain),
    .write_enb_reg(write_enb_reg), .read_enb(rd[2:0]), .empty(emp[2:0]), .full(ful[2:0]),
    .write_enb(we0), .fifo_full(ff0), .vld_out(vld0), .soft_reset(sr0), .addr_err(ae0)
  );

  router_sync_n #(.NUM_CH(4), .TIMEOUT(5)) u1 (
    .clk(clk), .reset(reset), .detect_add(detect_add), .datain(datain),
    .write_enb_reg(write_enb_reg), .read_enb(rd), .empty(emp), .full(ful),
    .write_enb(we1), .fifo_full(ff1), .vld_out(vld1), .soft_reset(sr1), .addr_err(ae1)
  );

  function automatic void model_clear();
    for (int m = 0; m < 2; m++) begin
      dest[m] = 0;
      err[m]  = 1'b0;
      for (int i = 0; i < 4; i++) begin
        run[m][i]   = 0;
        pulse[m][i] = 1'b0;
      end
    end
  endfunction

  // a pulse is due whenever the length of the current stall run is a positive multiple of the timeout
  function automatic void model_edge();
    if (reset) begin
      model_clear();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      if (detect_add) begin
        dest[m] = int'(datain);
        err[m]  = int'(datain) >= nch[m];
      end
      for (int i = 0; i < nch[m]; i++) begin
        run[m][i]   = (!emp[i] && !rd[i]) ? run[m][i] + 1 : 0;
        pulse[m][i] = run[m][i] > 0 && run[m][i] % tmo[m] == 0;
      end
    end
  endfunction

  function automatic bit pulse_any();
    bit p = 1'b0;
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 4; i++) p |= pulse[m][i];
    return p;
  endfunction

  function automatic obs_t expect_of(int m);
    obs_t o = '0;
    for (int i = 0; i < nch[m]; i++) begin
      o.vld[i] = !emp[i];
      o.sr[i]  = pulse[m][i];
    end
    if (dest[m] < nch[m]) begin
      if (write_enb_reg) o.we[dest[m]] = 1'b1;
      o.ff = ful[dest[m]];
    end
    o.ae = err[m];
    return o;
  endfunction

  task automatic push_expect();
    exp_t e;
    e.a = expect_of(0);
    e.b = expect_of(1);
    q.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // monitor: every output cycle is checked against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        cmp("we0", {1'b0, we0}, e.a.we);
        cmp("ff0", {3'b0, ff0}, {3'b0, e.a.ff});
        cmp("vld0", {1'b0, vld0}, e.a.vld);
        cmp("sr0", {1'b0, sr0}, e.a.sr);
        cmp("ae0", {3'b0, ae0}, {3'b0, e.a.ae});
        cmp("we1", we1, e.b.we);
        cmp("ff1", {3'b0, ff1}, {3'b0, e.b.ff});
        cmp("vld1", vld1, e.b.vld);
        cmp("sr1", sr1, e.b.sr);
        cmp("ae1", {3'b0, ae1}, {3'b0, e.b.ae});
        if (e.a.sr != 0 || e.b.sr != 0) npulse++;
      end
    end
  end

  // stimulus: alternating fully random and stall-heavy segments, with resets landing on pulses
  initial begin
    int mode;
    model_clear();
    repeat (2) begin
      @(posedge clk);
      model_edge();
      #1;
      push_expect();
    end
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      model_edge();
      #1;
      mode = (c / 250) % 2;
      reset = 1'b0;
      if (mode == 1 && pulse_any() && nrst < 8) begin
        reset = 1'b1;
        nrst++;
        model_clear();
      end
      detect_add    = $urandom_range(0, 3) == 0;
      datain        = 2'($urandom);
      write_enb_reg = 1'($urandom);
      ful           = 4'($urandom);
      if (mode == 0) begin
        rd  = 4'($urandom);
        emp = 4'($urandom);
      end else begin
        for (int j = 0; j < 4; j++) begin
          rd[j]  = $urandom_range(0, 127) == 0;
          emp[j] = $urandom_range(0, 127) == 0;
        end
      end
      push_expect();
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 pending expectations", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
